// File: rtl/obi_line_xfer_master.sv
// OBI initiator moving whole cache lines: one burst read per refill, one
// single-word write per beat (with idle gaps) per writeback.
module obi_line_xfer_master #(
  parameter int unsigned LINE_BEATS     = 8,
  parameter int unsigned WR_GAP         = 2,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     line_req_i,
  input  logic                     line_we_i,
  input  logic [63:0]              line_addr_i,
  input  logic [64*LINE_BEATS-1:0] line_wdata_i,
  output logic                     line_ready_o,
  output logic                     line_done_o,
  output logic                     line_err_o,
  output logic [64*LINE_BEATS-1:0] line_rdata_o,
  output logic                     obi_req_o,
  output logic                     obi_we_o,
  output logic [7:0]               obi_be_o,
  output logic [63:0]              obi_addr_o,
  output logic [63:0]              obi_wdata_o,
  input  logic                     obi_gnt_i,
  input  logic                     obi_rvalid_i,
  input  logic [63:0]              obi_rdata_i
);

  localparam int unsigned LINE_W     = 64 * LINE_BEATS;
  localparam int unsigned LINE_BYTES = LINE_BEATS * 8;
  localparam int unsigned KW         = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
  localparam int unsigned GW         = (WR_GAP > 1) ? $clog2(WR_GAP) : 1;
  localparam int unsigned TW         = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [KW-1:0] K_LAST    = KW'(LINE_BEATS - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'((WR_GAP > 0) ? WR_GAP - 1 : 0);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [63:0]   ADDR_MASK = ~64'(LINE_BYTES - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_RD_REQ, ST_RD_DATA, ST_WR_REQ, ST_WR_GAP, ST_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [KW-1:0]       k_q, k_d;
  logic [GW-1:0]       gap_q, gap_d;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic [63:0]         base_q, base_d;
  logic [LINE_W-1:0]   wbuf_q, wbuf_d;
  logic [LINE_W-1:0]   rdata_q, rdata_d;
  logic                err_flag;

  logic                req_q, req_d;
  logic                we_q, we_d;
  logic [7:0]          be_q, be_d;
  logic [63:0]         addr_q, addr_d;
  logic [63:0]         wdata_q, wdata_d;
  logic                ready_q, ready_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    gap_d    = gap_q;
    tmo_d    = tmo_q;
    base_d   = base_q;
    wbuf_d   = wbuf_q;
    rdata_d  = rdata_q;
    err_flag = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (line_req_i) begin
          base_d  = line_addr_i & ADDR_MASK;
          wbuf_d  = line_wdata_i;
          k_d     = '0;
          gap_d   = '0;
          tmo_d   = '0;
          state_d = line_we_i ? ST_WR_REQ : ST_RD_REQ;
        end
      end
      ST_RD_REQ: begin
        // a beat arriving together with the grant is not part of this burst
        if (obi_gnt_i) begin
          tmo_d   = '0;
          state_d = ST_RD_DATA;
        end
      end
      ST_RD_DATA: begin
        if (obi_rvalid_i) begin
          rdata_d[k_q*64 +: 64] = obi_rdata_i;
          tmo_d = '0;
          if (k_q == K_LAST) state_d = ST_DONE;
          else               k_d     = k_q + 1'b1;
        end else if (tmo_q == TMO_LAST) begin
          err_flag = 1'b1;
          state_d  = ST_DONE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_WR_REQ: begin
        if (obi_gnt_i) begin
          if (k_q == K_LAST) begin
            state_d = ST_DONE;
          end else begin
            k_d     = k_q + 1'b1;
            gap_d   = '0;
            state_d = (WR_GAP > 0) ? ST_WR_GAP : ST_WR_REQ;
          end
        end
      end
      ST_WR_GAP: begin
        if (gap_q == GAP_LAST) state_d = ST_WR_REQ;
        else                   gap_d   = gap_q + 1'b1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so they leave the block registered.
    req_d   = (state_d == ST_RD_REQ) || (state_d == ST_WR_REQ);
    we_d    = (state_d == ST_WR_REQ);
    be_d    = req_d ? 8'hFF : 8'h00;
    addr_d  = '0;
    wdata_d = '0;
    if (state_d == ST_RD_REQ) addr_d = base_d;
    if (state_d == ST_WR_REQ) begin
      addr_d  = base_d + {{(64-KW-3){1'b0}}, k_d, 3'b000};
      wdata_d = wbuf_d[k_d*64 +: 64];
    end
    ready_d = (state_d == ST_IDLE);
    done_d  = (state_d == ST_DONE);
    err_d   = err_flag;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      gap_q   <= '0;
      tmo_q   <= '0;
      base_q  <= '0;
      wbuf_q  <= '0;
      rdata_q <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= 8'h00;
      addr_q  <= '0;
      wdata_q <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      gap_q   <= gap_d;
      tmo_q   <= tmo_d;
      base_q  <= base_d;
      wbuf_q  <= wbuf_d;
      rdata_q <= rdata_d;
      req_q   <= req_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign line_ready_o = ready_q;
  assign line_done_o  = done_q;
  assign line_err_o   = err_q;
  assign line_rdata_o = rdata_q;
  assign obi_req_o    = req_q;
  assign obi_we_o     = we_q;
  assign obi_be_o     = be_q;
  assign obi_addr_o   = addr_q;
  assign obi_wdata_o  = wdata_q;

endmodule
